// File: rtl/cdb_receiver_station.sv
// cdb_receiver_station: reservation station that snoops the common data bus.
// Entries form a collapsing, age-ordered queue (index 0 is oldest). Each entry
// waits for its two source operands, either supplied at dispatch or captured
// from a CDB broadcast by tag match. The oldest entry with both operands ready
// is offered to the functional unit.
// Optional feature macro: CDB_RECEIVER_ISSUE_BYPASS_EN. When defined, an entry
// whose last missing operand is on the CDB this cycle may issue in the same
// cycle, with that operand forwarded straight from i_cdb_data.
module cdb_receiver_station #(
  parameter int BW_PROCESSOR_DATA = 32,
  parameter int BW_TAG            = 4,
  parameter int BW_OP             = 4,
  parameter int NUM_ENTRY         = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_disp_valid,
  output logic                             o_disp_ready,
  input  logic [BW_OP-1:0]                 i_disp_op,
  input  logic [BW_TAG-1:0]                i_disp_dest_tag,
  input  logic                             i_disp_src1_rdy,
  input  logic [BW_TAG-1:0]                i_disp_src1_tag,
  input  logic [BW_PROCESSOR_DATA-1:0]     i_disp_src1_data,
  input  logic                             i_disp_src2_rdy,
  input  logic [BW_TAG-1:0]                i_disp_src2_tag,
  input  logic [BW_PROCESSOR_DATA-1:0]     i_disp_src2_data,
  input  logic                             i_cdb_valid,
  input  logic [BW_TAG-1:0]                i_cdb_tag,
  input  logic [BW_PROCESSOR_DATA-1:0]     i_cdb_data,
  output logic                             o_issue_valid,
  input  logic                             i_issue_ready,
  output logic [BW_OP-1:0]                 o_issue_op,
  output logic [BW_TAG-1:0]                o_issue_dest_tag,
  output logic [BW_PROCESSOR_DATA-1:0]     o_issue_src1_data,
  output logic [BW_PROCESSOR_DATA-1:0]     o_issue_src2_data,
  input  logic                             i_flush,
  output logic [$clog2(NUM_ENTRY+1)-1:0]   o_count
);

  localparam int CW = $clog2(NUM_ENTRY + 1);
  localparam int IW = $clog2(NUM_ENTRY);

  // Payload of one station slot; the valid bit is kept separately so that
  // only it needs a reset.
  typedef struct packed {
    logic [BW_OP-1:0]             op;
    logic [BW_TAG-1:0]            dest_tag;
    logic                         s1_rdy;
    logic [BW_TAG-1:0]            s1_tag;
    logic [BW_PROCESSOR_DATA-1:0] s1_data;
    logic                         s2_rdy;
    logic [BW_TAG-1:0]            s2_tag;
    logic [BW_PROCESSOR_DATA-1:0] s2_data;
  } entry_t;

  logic            r_valid [NUM_ENTRY];
  entry_t          r_ent   [NUM_ENTRY];
  logic [CW-1:0]   r_count;

  entry_t          w_cap      [NUM_ENTRY];
  entry_t          w_sel_src  [NUM_ENTRY];
  entry_t          w_nxt_ent  [NUM_ENTRY];
  logic            w_nxt_valid[NUM_ENTRY];
  entry_t          w_disp_ent;
  logic            w_any;
  logic [IW-1:0]   w_sel;
  logic            w_issue_hs;
  logic            w_disp_hs;
  logic [CW-1:0]   w_wr_idx;

  // Apply a CDB broadcast to an entry: any waiting source with a matching tag
  // picks up the broadcast data and becomes ready.
  function automatic entry_t snoop(input entry_t e, input logic v,
                                   input logic [BW_TAG-1:0] t,
                                   input logic [BW_PROCESSOR_DATA-1:0] d);
    entry_t r;
    r = e;
    if (v && !e.s1_rdy && (e.s1_tag == t)) begin
      r.s1_rdy  = 1'b1;
      r.s1_data = d;
    end
    if (v && !e.s2_rdy && (e.s2_tag == t)) begin
      r.s2_rdy  = 1'b1;
      r.s2_data = d;
    end
    return r;
  endfunction

  // Snoop the CDB for every stored entry and for the entry being dispatched,
  // so a broadcast coinciding with dispatch is never lost.
  always_comb begin
    for (int i = 0; i < NUM_ENTRY; i++) begin
      w_cap[i] = snoop(r_ent[i], i_cdb_valid, i_cdb_tag, i_cdb_data);
    end
    w_disp_ent = snoop('{op: i_disp_op, dest_tag: i_disp_dest_tag,
                         s1_rdy: i_disp_src1_rdy, s1_tag: i_disp_src1_tag,
                         s1_data: i_disp_src1_data,
                         s2_rdy: i_disp_src2_rdy, s2_tag: i_disp_src2_tag,
                         s2_data: i_disp_src2_data},
                       i_cdb_valid, i_cdb_tag, i_cdb_data);
  end

`ifdef CDB_RECEIVER_ISSUE_BYPASS_EN
  // Issue selection sees this cycle's CDB wakeups (combinational forward).
  assign w_sel_src = w_cap;
`else
  // Issue selection sees only registered operand state.
  assign w_sel_src = r_ent;
`endif

  // Pick the oldest (lowest index) entry with both operands ready.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and a latch is never inferred.
    w_any = 1'b0;
    w_sel = '0;
    for (int i = NUM_ENTRY - 1; i >= 0; i--) begin
      if (r_valid[i] && w_sel_src[i].s1_rdy && w_sel_src[i].s2_rdy) begin
        w_any = 1'b1;
        w_sel = IW'(i);
      end
    end
  end

  assign o_issue_valid = w_any && !i_flush && !rst;
  assign o_disp_ready  = (r_count < CW'(NUM_ENTRY)) && !i_flush;
  assign o_count       = r_count;
  assign w_issue_hs    = o_issue_valid && i_issue_ready;
  assign w_disp_hs     = i_disp_valid && o_disp_ready;
  assign w_wr_idx      = r_count - CW'(w_issue_hs);

  // Drive issue fields from the selected entry, zero when nothing is offered.
  always_comb begin
    o_issue_op        = '0;
    o_issue_dest_tag  = '0;
    o_issue_src1_data = '0;
    o_issue_src2_data = '0;
    if (o_issue_valid) begin
      o_issue_op        = w_sel_src[w_sel].op;
      o_issue_dest_tag  = w_sel_src[w_sel].dest_tag;
      o_issue_src1_data = w_sel_src[w_sel].s1_data;
      o_issue_src2_data = w_sel_src[w_sel].s2_data;
    end
  end

  // Next queue image: collapse over the issued slot, then append the dispatch
  // at the first free index after the collapse.
  always_comb begin
    for (int i = 0; i < NUM_ENTRY - 1; i++) begin
      if (w_issue_hs && (IW'(i) >= w_sel)) begin
        w_nxt_valid[i] = r_valid[i+1];
        w_nxt_ent[i]   = w_cap[i+1];
      end else begin
        w_nxt_valid[i] = r_valid[i];
        w_nxt_ent[i]   = w_cap[i];
      end
    end
    w_nxt_valid[NUM_ENTRY-1] = r_valid[NUM_ENTRY-1] && !w_issue_hs;
    w_nxt_ent[NUM_ENTRY-1]   = w_cap[NUM_ENTRY-1];
    for (int i = 0; i < NUM_ENTRY; i++) begin
      if (w_disp_hs && (CW'(i) == w_wr_idx)) begin
        w_nxt_valid[i] = 1'b1;
        w_nxt_ent[i]   = w_disp_ent;
      end
    end
  end

  // Occupancy state: reset and flush empty the station.
  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignment so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst || i_flush) begin
      r_count <= '0;
      for (int i = 0; i < NUM_ENTRY; i++) r_valid[i] <= 1'b0;
    end else begin
      r_count <= r_count + CW'(w_disp_hs) - CW'(w_issue_hs);
      for (int i = 0; i < NUM_ENTRY; i++) r_valid[i] <= w_nxt_valid[i];
    end
  end

  // Entry payload storage.
  always_ff @(posedge clk) begin
    // NOTE: payload is deliberately not reset; it is only observed through a
    // valid bit, which is reset, so stale contents are never visible.
    for (int i = 0; i < NUM_ENTRY; i++) r_ent[i] <= w_nxt_ent[i];
  end

endmodule

// File: tb/tb_cdb_receiver_station.sv
// Testbench for cdb_receiver_station. A queue-based reference model predicts
// every output each cycle; directed scenarios add explicit value checks.
// Works with or without CDB_RECEIVER_ISSUE_BYPASS_EN defined.
module tb_cdb_receiver_station;

  localparam int DW = 32, TW = 4, OW = 4, N = 4, CW = 3;
  localparam int OBS_W = 2 + OW + TW + 2 * DW + CW;
`ifdef CDB_RECEIVER_ISSUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_disp_valid = 0, o_disp_ready;
  logic [OW-1:0] i_disp_op = '0;
  logic [TW-1:0] i_disp_dest_tag = '0;
  logic i_disp_src1_rdy = 0, i_disp_src2_rdy = 0;
  logic [TW-1:0] i_disp_src1_tag = '0, i_disp_src2_tag = '0;
  logic [DW-1:0] i_disp_src1_data = '0, i_disp_src2_data = '0;
  logic i_cdb_valid = 0;
  logic [TW-1:0] i_cdb_tag = '0;
  logic [DW-1:0] i_cdb_data = '0;
  logic o_issue_valid, i_issue_ready = 0, i_flush = 0;
  logic [OW-1:0] o_issue_op;
  logic [TW-1:0] o_issue_dest_tag;
  logic [DW-1:0] o_issue_src1_data, o_issue_src2_data;
  logic [CW-1:0] o_count;
  logic [OBS_W-1:0] obs;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cdb_receiver_station #(.BW_PROCESSOR_DATA(DW), .BW_TAG(TW), .BW_OP(OW),
                         .NUM_ENTRY(N)) dut (
    .clk(clk), .rst(rst),
    .i_disp_valid(i_disp_valid), .o_disp_ready(o_disp_ready),
    .i_disp_op(i_disp_op), .i_disp_dest_tag(i_disp_dest_tag),
    .i_disp_src1_rdy(i_disp_src1_rdy), .i_disp_src1_tag(i_disp_src1_tag),
    .i_disp_src1_data(i_disp_src1_data),
    .i_disp_src2_rdy(i_disp_src2_rdy), .i_disp_src2_tag(i_disp_src2_tag),
    .i_disp_src2_data(i_disp_src2_data),
    .i_cdb_valid(i_cdb_valid), .i_cdb_tag(i_cdb_tag), .i_cdb_data(i_cdb_data),
    .o_issue_valid(o_issue_valid), .i_issue_ready(i_issue_ready),
    .o_issue_op(o_issue_op), .o_issue_dest_tag(o_issue_dest_tag),
    .o_issue_src1_data(o_issue_src1_data), .o_issue_src2_data(o_issue_src2_data),
    .i_flush(i_flush), .o_count(o_count)
  );

  assign obs = {o_disp_ready, o_issue_valid, o_issue_op, o_issue_dest_tag,
                o_issue_src1_data, o_issue_src2_data, o_count};

  // ---------------- reference model: a plain age-ordered queue --------------
  typedef struct {
    logic [OW-1:0] op;
    logic [TW-1:0] dest;
    logic          r1;
    logic [TW-1:0] t1;
    logic [DW-1:0] d1;
    logic          r2;
    logic [TW-1:0] t2;
    logic [DW-1:0] d2;
  } ment_t;

  typedef struct {
    ment_t         e;
    logic          dv;
    logic          cv;
    logic [TW-1:0] ct;
    logic [DW-1:0] cd;
    logic          ir;
    logic          fl;
    logic          rs;
  } stim_t;

  ment_t mq[$];

  function automatic ment_t ent(int op, int dest, bit r1, int t1, int d1,
                                bit r2, int t2, int d2);
    ment_t e;
    e.op = OW'(op); e.dest = TW'(dest);
    e.r1 = r1; e.t1 = TW'(t1); e.d1 = DW'(d1);
    e.r2 = r2; e.t2 = TW'(t2); e.d2 = DW'(d2);
    return e;
  endfunction

  function automatic stim_t idle(bit ir);
    stim_t s;
    s.e = ent(0, 0, 0, 0, 0, 0, 0, 0);
    s.dv = 0; s.cv = 0; s.ct = '0; s.cd = '0;
    s.ir = ir; s.fl = 0; s.rs = 0;
    return s;
  endfunction

  // True when a waiting source is woken by the broadcast on the bus now.
  function automatic logic wakes(logic r, logic [TW-1:0] t);
    return !r && i_cdb_valid && (t == i_cdb_tag);
  endfunction

  // Oldest entry that may issue this cycle, or -1.
  function automatic int model_sel();
    for (int i = 0; i < mq.size(); i++) begin
      if ((mq[i].r1 || (BYP && wakes(mq[i].r1, mq[i].t1))) &&
          (mq[i].r2 || (BYP && wakes(mq[i].r2, mq[i].t2))))
        return i;
    end
    return -1;
  endfunction

  function automatic logic [OBS_W-1:0] model_obs();
    int s;
    logic rdy, vld;
    logic [OW-1:0] op;
    logic [TW-1:0] dst;
    logic [DW-1:0] a, b;
    s   = model_sel();
    rdy = (mq.size() < N) && !i_flush;
    vld = (s >= 0) && !i_flush && !rst;
    op = '0; dst = '0; a = '0; b = '0;
    if (vld) begin
      op  = mq[s].op;
      dst = mq[s].dest;
      a   = mq[s].r1 ? mq[s].d1 : i_cdb_data;
      b   = mq[s].r2 ? mq[s].d2 : i_cdb_data;
    end
    return {rdy, vld, op, dst, a, b, CW'(mq.size())};
  endfunction

  task automatic drive(input stim_t s);
    i_disp_valid     = s.dv;
    i_disp_op        = s.e.op;
    i_disp_dest_tag  = s.e.dest;
    i_disp_src1_rdy  = s.e.r1;
    i_disp_src1_tag  = s.e.t1;
    i_disp_src1_data = s.e.d1;
    i_disp_src2_rdy  = s.e.r2;
    i_disp_src2_tag  = s.e.t2;
    i_disp_src2_data = s.e.d2;
    i_cdb_valid      = s.cv;
    i_cdb_tag        = s.ct;
    i_cdb_data       = s.cd;
    i_issue_ready    = s.ir;
    i_flush          = s.fl;
    rst              = s.rs;
    #1;
  endtask

  // Move the model across the coming clock edge, then wait for the next
  // negative edge where new stimulus is applied.
  task automatic advance();
    int    s;
    bit    iss, dsp;
    ment_t e;
    s   = model_sel();
    iss = (s >= 0) && !i_flush && !rst && i_issue_ready;
    dsp = i_disp_valid && (mq.size() < N) && !i_flush;
    if (rst || i_flush) begin
      mq.delete();
    end else begin
      for (int i = 0; i < mq.size(); i++) begin
        if (wakes(mq[i].r1, mq[i].t1)) begin mq[i].r1 = 1; mq[i].d1 = i_cdb_data; end
        if (wakes(mq[i].r2, mq[i].t2)) begin mq[i].r2 = 1; mq[i].d2 = i_cdb_data; end
      end
      if (iss) mq.delete(s);
      if (dsp) begin
        e = ent(i_disp_op, i_disp_dest_tag, i_disp_src1_rdy, i_disp_src1_tag,
                i_disp_src1_data, i_disp_src2_rdy, i_disp_src2_tag,
                i_disp_src2_data);
        if (wakes(e.r1, e.t1)) begin e.r1 = 1; e.d1 = i_cdb_data; end
        if (wakes(e.r2, e.t2)) begin e.r2 = 1; e.d2 = i_cdb_data; end
        mq.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    stim_t s;
    s = idle(1);
    s.rs = 1; s.dv = 1; s.e = ent(1, 1, 1, 0, 1, 1, 0, 1);
    for (int k = 0; k < 2; k++) begin
      drive(s);
      n_checks++;
      if ({o_issue_valid, o_issue_op, o_issue_dest_tag, o_issue_src1_data,
           o_issue_src2_data} !== '0) begin
        n_errors++;
        $display("FAIL reset_issue_outputs: got valid=%b op=%h dest=%h s1=%h s2=%h required all zero",
                 o_issue_valid, o_issue_op, o_issue_dest_tag, o_issue_src1_data, o_issue_src2_data);
      end
      advance();
    end
    drive(idle(0));
    n_checks++;
    if ({o_disp_ready, o_issue_valid, o_count} !== {1'b1, 1'b0, 3'd0}) begin
      n_errors++;
      $display("FAIL reset_release: got ready=%b valid=%b count=%0d required ready=1 valid=0 count=0",
               o_disp_ready, o_issue_valid, o_count);
    end
    advance();
  endtask

  task automatic test_basic();
    stim_t s;
    s = idle(1);
    s.dv = 1; s.e = ent(3, 5, 1, 0, 10, 1, 0, 20);
    drive(s);
    n_checks++;
    if (obs !== model_obs()) begin n_errors++; $display("FAIL basic_model: got %h required %h", obs, model_obs()); end
    advance();
    drive(idle(1));
    n_checks++;
    if ({o_issue_valid, o_issue_op, o_issue_dest_tag, o_issue_src1_data, o_issue_src2_data, o_count}
        !== {1'b1, 4'd3, 4'd5, 32'd10, 32'd20, 3'd1}) begin
      n_errors++;
      $display("FAIL basic_issue: got valid=%b op=%0d dest=%0d s1=%0d s2=%0d count=%0d required 1/3/5/10/20/1",
               o_issue_valid, o_issue_op, o_issue_dest_tag, o_issue_src1_data, o_issue_src2_data, o_count);
    end
    advance();
    drive(idle(1));
    n_checks++;
    if ({o_issue_valid, o_count} !== {1'b0, 3'd0}) begin
      n_errors++;
      $display("FAIL basic_drain: got valid=%b count=%0d required 0/0", o_issue_valid, o_count);
    end
    advance();
  endtask

  task automatic test_cdb_wakeup();
    stim_t s;
    logic [DW-1:0] want;
    for (int k = 0; k <= 5; k++) begin
      s = idle(1);
      if (k == 0) begin s.dv = 1; s.e = ent(2, 8, 0, 7, 0, 1, 0, 1); end
      if (k == 3) begin s.cv = 1; s.ct = 4'd7; s.cd = 32'hDEAD; end
      drive(s);
      n_checks++;
      if (obs !== model_obs()) begin n_errors++; $display("FAIL wakeup_model: cycle %0d got %h required %h", k, obs, model_obs()); end
      if (k == 3 || k == 4) begin
        want = ((k == 3) == BYP) ? 32'hDEAD : 32'd0;
        n_checks++;
        if ({o_issue_valid, o_issue_valid ? o_issue_src1_data : 32'd0} !== {(k == 3) == BYP, want}) begin
          n_errors++;
          $display("FAIL wakeup_issue: cycle %0d got valid=%b s1=%h required valid=%b s1=%h",
                   k, o_issue_valid, o_issue_src1_data, (k == 3) == BYP, want);
        end
      end
      advance();
    end
  endtask

  task automatic test_disp_capture();
    stim_t s;
    s = idle(1);
    s.dv = 1; s.e = ent(9, 3, 1, 0, 5, 0, 2, 0);
    s.cv = 1; s.ct = 4'd2; s.cd = 32'd99;
    drive(s);
    n_checks++;
    if (obs !== model_obs()) begin n_errors++; $display("FAIL capture_model: got %h required %h", obs, model_obs()); end
    advance();
    drive(idle(1));
    n_checks++;
    if ({o_issue_valid, o_issue_src1_data, o_issue_src2_data} !== {1'b1, 32'd5, 32'd99}) begin
      n_errors++;
      $display("FAIL capture_issue: got valid=%b s1=%0d s2=%0d required 1/5/99",
               o_issue_valid, o_issue_src1_data, o_issue_src2_data);
    end
    advance();
  endtask

  task automatic test_full();
    stim_t s;
    for (int i = 0; i < N; i++) begin
      s = idle(0);
      s.dv = 1; s.e = ent(i + 1, i, 1, 0, 100 + i, 1, 0, 200 + i);
      drive(s);
      n_checks++;
      if (obs !== model_obs()) begin n_errors++; $display("FAIL full_fill: entry %0d got %h required %h", i, obs, model_obs()); end
      advance();
    end
    s = idle(0);
    s.dv = 1; s.e = ent(5, 9, 1, 0, 105, 1, 0, 205);
    drive(s);
    n_checks++;
    if ({o_disp_ready, o_count, o_issue_valid, o_issue_op} !== {1'b0, 3'd4, 1'b1, 4'd1}) begin
      n_errors++;
      $display("FAIL full_stall: got ready=%b count=%0d valid=%b op=%0d required 0/4/1/1",
               o_disp_ready, o_count, o_issue_valid, o_issue_op);
    end
    advance();
    s.ir = 1;
    drive(s);
    n_checks++;
    if ({o_disp_ready, o_issue_op} !== {1'b0, 4'd1}) begin
      n_errors++;
      $display("FAIL full_no_credit: got ready=%b op=%0d required 0/1", o_disp_ready, o_issue_op);
    end
    advance();
    s.ir = 0;
    drive(s);
    n_checks++;
    if ({o_disp_ready, o_count, o_issue_op} !== {1'b1, 3'd3, 4'd2}) begin
      n_errors++;
      $display("FAIL full_accept: got ready=%b count=%0d op=%0d required 1/3/2", o_disp_ready, o_count, o_issue_op);
    end
    advance();
    for (int k = 0; k < N; k++) begin
      drive(idle(1));
      n_checks++;
      if ({o_issue_valid, o_issue_op} !== {1'b1, OW'(k + 2)}) begin
        n_errors++;
        $display("FAIL full_order: slot %0d got valid=%b op=%0d required 1/%0d", k, o_issue_valid, o_issue_op, k + 2);
      end
      advance();
    end
  endtask

  task automatic test_out_of_order();
    stim_t s;
    s = idle(0);
    s.dv = 1; s.e = ent(6, 1, 0, 1, 0, 1, 0, 60);
    drive(s); advance();
    s.e = ent(7, 2, 1, 0, 70, 1, 0, 71);
    drive(s); advance();
    drive(idle(1));
    n_checks++;
    if ({o_issue_valid, o_issue_op, o_count} !== {1'b1, 4'd7, 3'd2}) begin
      n_errors++;
      $display("FAIL ooo_younger_first: got valid=%b op=%0d count=%0d required 1/7/2", o_issue_valid, o_issue_op, o_count);
    end
    advance();
    s = idle(1);
    s.cv = 1; s.ct = 4'd1; s.cd = 32'h111;
    drive(s);
    n_checks++;
    if ({o_issue_valid, o_issue_valid ? o_issue_op : 4'd0} !== {BYP, BYP ? 4'd6 : 4'd0}) begin
      n_errors++;
      $display("FAIL ooo_broadcast_cycle: got valid=%b op=%0d required valid=%b", o_issue_valid, o_issue_op, BYP);
    end
    advance();
    drive(idle(1));
    n_checks++;
    if ({o_issue_valid, o_issue_valid ? o_issue_src1_data : 32'd0} !== {!BYP, BYP ? 32'd0 : 32'h111}) begin
      n_errors++;
      $display("FAIL ooo_older_next: got valid=%b s1=%h required valid=%b", o_issue_valid, o_issue_src1_data, !BYP);
    end
    advance();
  endtask

  task automatic test_flush_reset();
    stim_t s;
    s = idle(0);
    s.dv = 1;
    for (int i = 0; i < 3; i++) begin
      s.e = ent(i + 1, i, 1, 0, i, i != 2, 9, i);
      drive(s); advance();
    end
    s.fl = 1; s.ir = 1; s.e = ent(4, 4, 1, 0, 4, 1, 0, 4);
    drive(s);
    n_checks++;
    if ({o_issue_valid, o_disp_ready, o_count} !== {1'b0, 1'b0, 3'd3}) begin
      n_errors++;
      $display("FAIL flush_cycle: got valid=%b ready=%b count=%0d required 0/0/3", o_issue_valid, o_disp_ready, o_count);
    end
    advance();
    drive(idle(0));
    n_checks++;
    if ({o_issue_valid, o_count} !== {1'b0, 3'd0}) begin
      n_errors++;
      $display("FAIL flush_after: got valid=%b count=%0d required 0/0", o_issue_valid, o_count);
    end
    advance();
    s = idle(1);
    s.dv = 1; s.e = ent(4, 4, 0, 10, 0, 1, 0, 4);
    drive(s); advance();
    drive(idle(1)); advance();
    s = idle(1);
    s.rs = 1; s.fl = 1; s.cv = 1; s.ct = 4'd10; s.cd = 32'h5A;
    drive(s);
    n_checks++;
    if (o_issue_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_mid_wait: got valid=%b required 0", o_issue_valid);
    end
    advance();
    drive(idle(1));
    n_checks++;
    if ({o_count, o_issue_valid, o_disp_ready} !== {3'd0, 1'b0, 1'b1}) begin
      n_errors++;
      $display("FAIL reset_mid_after: got count=%0d valid=%b ready=%b required 0/0/1", o_count, o_issue_valid, o_disp_ready);
    end
    advance();
  endtask

  task automatic test_random();
    stim_t s;
    for (int k = 0; k < 600; k++) begin
      s = idle($urandom_range(0, 9) < 7);
      s.dv = $urandom_range(0, 9) < 6;
      s.e  = ent($urandom_range(0, 15), $urandom_range(0, 15),
                 $urandom_range(0, 1), $urandom_range(0, 3), $urandom,
                 $urandom_range(0, 1), $urandom_range(0, 3), $urandom);
      s.cv = $urandom_range(0, 1);
      s.ct = TW'($urandom_range(0, 3));
      s.cd = $urandom;
      s.fl = $urandom_range(0, 99) < 3;
      s.rs = $urandom_range(0, 99) < 1;
      drive(s);
      n_checks++;
      if (obs !== model_obs()) begin
        n_errors++;
        $display("FAIL random_model: cycle %0d got %h required %h", k, obs, model_obs());
      end
      advance();
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_cdb_wakeup();
    test_disp_capture();
    test_full();
    test_out_of_order();
    test_flush_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cdb_receiver_station.md
CDB_RECEIVER_STATION -- requirements
Module: cdb_receiver_station

Interface
REQ-001 SHALL have parameter BW_PROCESSOR_DATA, default 32, operand/result data width.
REQ-002 SHALL have parameter BW_TAG, default 4, CDB/rename tag width.
REQ-003 SHALL have parameter BW_OP, default 4, opcode width.
REQ-004 SHALL have parameter NUM_ENTRY, default 4, station depth (>=2).
REQ-005 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  reset; one clock; synchronous and active-high.
REQ-007 SHALL have ports i_disp_valid input 1 and o_disp_ready output 1; dispatch handshake.
REQ-008 SHALL have ports i_disp_op input BW_OP and i_disp_dest_tag input BW_TAG; opcode and result tag.
REQ-009 SHALL have, for k in {1,2}, i_disp_srck_rdy input 1, i_disp_srck_tag input BW_TAG, i_disp_srck_data input BW_PROCESSOR_DATA; rdy=1 means data valid, else wait for tag.
REQ-010 SHALL have ports i_cdb_valid input 1, i_cdb_tag input BW_TAG, i_cdb_data input BW_PROCESSOR_DATA; broadcast snoop, no ready.
REQ-011 SHALL have ports o_issue_valid output 1 and i_issue_ready input 1; issue handshake to functional unit.
REQ-012 SHALL have ports o_issue_op BW_OP, o_issue_dest_tag BW_TAG, o_issue_src1_data and o_issue_src2_data BW_PROCESSOR_DATA; all outputs.
REQ-013 SHALL have port i_flush input 1; discard all entries.
REQ-014 SHALL have port o_count output $clog2(NUM_ENTRY+1); occupied entries.

Function
REQ-015 Entries SHALL form a collapsing age-ordered queue: index 0 oldest; each holds valid, op, dest_tag, per-source rdy/tag/data.
REQ-016 o_disp_ready SHALL equal (o_count < NUM_ENTRY) && !i_flush; no same-cycle free-on-issue credit.
REQ-017 Dispatch handshake SHALL write the new entry at index o_count, or o_count-1 when an issue handshake occurs in the same cycle.
REQ-018 Each cycle with i_cdb_valid, every valid entry source with rdy=0 and tag==i_cdb_tag SHALL capture i_cdb_data and set rdy=1 at the next edge.
REQ-019 A dispatching source with rdy=0 whose tag equals i_cdb_tag while i_cdb_valid SHALL be stored with rdy=1 and i_cdb_data (no lost wakeup).
REQ-020 An entry is issuable when valid and both sources rdy; o_issue_valid SHALL be 1 iff any issuable entry exists; the lowest-index issuable entry is selected.
REQ-021 Issue outputs SHALL present the selected entry's fields and SHALL remain stable while o_issue_valid && !i_issue_ready unless an older entry becomes issuable.
REQ-022 On issue handshake the selected entry SHALL be removed and all younger entries shift down one index at the next edge.
REQ-023 o_count SHALL update as count + dispatch_hs - issue_hs.
REQ-024 i_flush SHALL force o_issue_valid=0 and o_disp_ready=0 that cycle and clear all entries at the next edge; flush overrides dispatch, issue and capture.
REQ-025 Without the configured bypass, earliest issue SHALL be one cycle after dispatch or after final CDB capture.
REQ-026 Tag compare SHALL be full BW_TAG equality; no tag value is reserved.

Reset
REQ-027 While rst=1 at an edge, all entries SHALL become invalid and o_count 0.
REQ-028 During and after reset, o_issue_valid SHALL be 0, o_disp_ready SHALL be 1 once rst deasserts, issue data/tag/op outputs SHALL be 0.
REQ-029 Reset asserted mid-operation SHALL drop all entries without issuing; rst has priority over i_flush.

Configuration
REQ-030 Macro CDB_RECEIVER_ISSUE_BYPASS_EN defined: an entry whose last missing source matches the current CDB broadcast SHALL be issuable the same cycle, missing operand forwarded combinationally from i_cdb_data.
REQ-031 Macro undefined: no combinational CDB-to-issue path; behaviour per REQ-025.

Verification
REQ-032 Dispatch op=3, dest=5, src1 rdy data=10, src2 rdy data=20 into empty station, i_issue_ready=1 -> next cycle o_issue_valid=1, src1=10, src2=20, dest=5; count 1->0.
REQ-033 Dispatch src1 tag=7 not rdy; 3 cycles later CDB tag=7 data=0xDEAD -> issue cycle after broadcast (same cycle with bypass macro) with src1=0xDEAD.
REQ-034 Dispatch src2 tag=2 not rdy in same cycle as CDB tag=2 data=99 -> entry stored rdy, issues next cycle with src2=99.
REQ-035 Fill 4 entries, i_issue_ready=0 -> o_disp_ready=0, count=4; raise ready with dispatch pending -> one issue, dispatch accepted following cycle, order preserved.
REQ-036 Entries 0 (waiting tag 1) and 1 (ready) -> entry 1 issues first; CDB tag=1 then entry 0 issues next.
REQ-037 i_flush with 3 entries and pending dispatch -> no issue, dispatch not accepted, count=0 next cycle; rst mid-wait -> count 0, o_issue_valid 0.
